sub_bytes_engine: RTL and testbench

- Parametrised, multi-cycle SubBytes unit for the AES datapath, succeeding the single-byte combinational substitution box.
- Accepts a DATA_W-bit state word over a valid/ready handshake and substitutes LANES bytes per cycle through parallel lookup lanes.
- Per-transaction mode selects the forward S-box (encryption) or the inverse S-box (decryption).
- Holds the result until the downstream round logic consumes it.

---
 rtl/sub_bytes_engine_if.sv | 26 ++
 rtl/sub_bytes_engine.sv | 142 ++++++++++++++
 tb/tb_sub_bytes_engine.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub_bytes_engine_if.sv
// Handshake bundle for the SubBytes engine: a valid/ready input channel carrying a state
// word plus mode, a valid/ready result channel, and a busy flag.
interface sub_bytes_engine_if #(
    parameter int DATA_W = 128
);
    // Valid/ready rule (both channels): a word moves on a rising edge where valid and ready
    // are both high; once valid is raised by the engine, it and the data stay put until taken.
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              inv_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              busy;

    modport master (
        output in_valid, in_data, inv_mode, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, inv_mode, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes: substitutes LANES bytes per cycle of a DATA_W-bit state word,
// forward or inverse S-box chosen per word, result held until the consumer takes it.
module sub_bytes_engine #(
    parameter int DATA_W     = 128,
    parameter int LANES      = 4,
    parameter int INVERSE_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    sub_bytes_engine_if.slave     sb,
    output logic [1:0]            state_o
);
    localparam int BEATS  = DATA_W / (8 * LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((LANES < 1) || (DATA_W % (8 * LANES) != 0)) begin : g_bad_params
        $error("sub_bytes_engine: DATA_W must be a multiple of 8*LANES");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                mode_q, mode_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    int                  base;
    logic [7:0]          lane_in  [LANES];
    logic [7:0]          lane_out [LANES];

    // Each table is a 16-way case on the high nibble returning one row; row column 0 sits in the top byte.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        logic [127:0] row;
        case (x[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            default: row = 128'h172b047eba77d626e169146355210c7d;
        endcase
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    assign base = int'(beat_q) * LANES;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_in[l] = data_q[(base + l) * 8 +: 8];
        if (INVERSE_EN != 0) begin : g_inv
            // Mode comes from the registered copy only, keeping inv_mode off any output path.
            assign lane_out[l] = mode_q ? sbox_inv(lane_in[l]) : sbox_fwd(lane_in[l]);
        end else begin : g_fwd_only
            assign lane_out[l] = sbox_fwd(lane_in[l]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            mode_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (sb.in_valid) begin
                    data_d  = sb.in_data;
                    mode_d  = sb.inv_mode & (INVERSE_EN != 0);
                    beat_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[(base + l) * 8 +: 8] = lane_out[l];
                end
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (sb.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sb.in_ready  = (state_q == IDLE);
    assign sb.out_valid = (state_q == DONE);
    assign sb.busy      = (state_q != IDLE);
    assign sb.out_data  = data_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: FIPS-197 vectors, reset abort, back-pressure,
// lane-count sweep and a full-table sweep against an arithmetic S-box model.
module tb_sub_bytes_engine;
    localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SUBST = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    sub_bytes_engine_if #(.DATA_W(128)) sb();
    sub_bytes_engine_if #(.DATA_W(128)) if_l1();
    sub_bytes_engine_if #(.DATA_W(128)) if_l2();
    sub_bytes_engine_if #(.DATA_W(128)) if_l16();
    sub_bytes_engine_if #(.DATA_W(128)) if_nf();
    logic [1:0] st_main, st_l1, st_l2, st_l16, st_nf;

    sub_bytes_engine #(.DATA_W(128), .LANES(4), .INVERSE_EN(1)) u_dut (
        .clk(clk), .reset(rst), .sb(sb), .state_o(st_main));
    sub_bytes_engine #(.DATA_W(128), .LANES(1), .INVERSE_EN(1)) u_l1 (
        .clk(clk), .reset(rst), .sb(if_l1), .state_o(st_l1));
    sub_bytes_engine #(.DATA_W(128), .LANES(2), .INVERSE_EN(1)) u_l2 (
        .clk(clk), .reset(rst), .sb(if_l2), .state_o(st_l2));
    sub_bytes_engine #(.DATA_W(128), .LANES(16), .INVERSE_EN(1)) u_l16 (
        .clk(clk), .reset(rst), .sb(if_l16), .state_o(st_l16));
    sub_bytes_engine #(.DATA_W(128), .LANES(4), .INVERSE_EN(0)) u_nf (
        .clk(clk), .reset(rst), .sb(if_nf), .state_o(st_nf));

    // Sweep instances share one stimulus; the forward-only one always asks for inverse.
    logic         sw_valid;
    logic [127:0] sw_data;
    logic         sw_ready;
    assign if_l1.in_valid   = sw_valid;
    assign if_l1.in_data    = sw_data;
    assign if_l1.inv_mode   = 1'b0;
    assign if_l1.out_ready  = sw_ready;
    assign if_l2.in_valid   = sw_valid;
    assign if_l2.in_data    = sw_data;
    assign if_l2.inv_mode   = 1'b0;
    assign if_l2.out_ready  = sw_ready;
    assign if_l16.in_valid  = sw_valid;
    assign if_l16.in_data   = sw_data;
    assign if_l16.inv_mode  = 1'b0;
    assign if_l16.out_ready = sw_ready;
    assign if_nf.in_valid   = sw_valid;
    assign if_nf.in_data    = sw_data;
    assign if_nf.inv_mode   = 1'b1;
    assign if_nf.out_ready  = sw_ready;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_ref();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            ref_fwd[x] = s;
            ref_inv[s] = 8'(x);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sends one word with out_ready high, returns result and cycles from accept edge to out_valid.
    task automatic run_word(input logic [127:0] d, input logic m,
                            output logic [127:0] res, output int lat);
        sb.in_data   = d;
        sb.inv_mode  = m;
        sb.in_valid  = 1'b1;
        sb.out_ready = 1'b1;
        step();
        sb.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (sb.out_valid) begin
                lat = k;
                break;
            end
        end
        res = sb.out_data;
        step();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] res;
        logic [127:0] held;
        logic [127:0] word;
        logic [127:0] exp_f;
        logic [127:0] exp_i;
        int           lat;
        int           lat_l1, lat_l2, lat_l16, lat_nf;
        logic [127:0] res_l1, res_l2, res_l16, res_nf;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        sb.in_valid = 1'b0;
        sb.in_data = '0;
        sb.inv_mode = 1'b0;
        sb.out_ready = 1'b0;
        sw_valid = 1'b0;
        sw_data = '0;
        sw_ready = 1'b0;
        build_ref();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(sb.in_ready), 128'd1);
        check("rst_out_valid", 128'(sb.out_valid), 128'd0);
        check("rst_busy", 128'(sb.busy), 128'd0);
        check("rst_out_data", sb.out_data, 128'd0);
        rst = 1'b0;
        step();

        // forward vector with latency
        sb.in_data = PLAIN;
        sb.inv_mode = 1'b0;
        sb.in_valid = 1'b1;
        sb.out_ready = 1'b1;
        step();
        sb.in_valid = 1'b0;
        check("acc_busy", 128'(sb.busy), 128'd1);
        check("acc_in_ready", 128'(sb.in_ready), 128'd0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (sb.out_valid) begin
                lat = k;
                break;
            end
        end
        check("fwd_latency", 128'(lat), 128'd4);
        check("fwd_data", sb.out_data, SUBST);
        step();
        check("fwd_idle_ready", 128'(sb.in_ready), 128'd1);
        check("fwd_idle_valid", 128'(sb.out_valid), 128'd0);

        // inverse round trip
        run_word(SUBST, 1'b1, res, lat);
        check("inv_latency", 128'(lat), 128'd4);
        check("inv_data", res, PLAIN);

        // single bytes: InvS(63)=00, InvS(ED)=53, S(00)=63, S(53)=ED, S(FF)=16
        word = 128'h0;
        word[7:0] = 8'h63;
        word[15:8] = 8'hed;
        run_word(word, 1'b1, res, lat);
        check("inv_63", 128'(res[7:0]), 128'h00);
        check("inv_ed", 128'(res[15:8]), 128'h53);
        word = 128'h0;
        word[15:8] = 8'h53;
        word[23:16] = 8'hff;
        run_word(word, 1'b0, res, lat);
        check("fwd_00", 128'(res[7:0]), 128'h63);
        check("fwd_53", 128'(res[15:8]), 128'hed);
        check("fwd_ff", 128'(res[23:16]), 128'h16);

        // reset in the middle of BUSY after 2 beats
        sb.in_data = PLAIN;
        sb.inv_mode = 1'b0;
        sb.in_valid = 1'b1;
        sb.out_ready = 1'b0;
        step();
        sb.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 128'(sb.out_valid), 128'd0);
        check("mid_rst_in_ready", 128'(sb.in_ready), 128'd1);
        check("mid_rst_busy", 128'(sb.busy), 128'd0);
        check("mid_rst_out_data", sb.out_data, 128'd0);
        #3;
        rst = 1'b0;
        sb.out_ready = 1'b1;
        step();
        sb.out_ready = 1'b0;
        step();
        check("post_rst_valid", 128'(sb.out_valid), 128'd0);
        check("post_rst_data", sb.out_data, 128'd0);
        check("post_rst_busy", 128'(sb.busy), 128'd0);

        // back-pressure
        sb.in_data = PLAIN;
        sb.inv_mode = 1'b0;
        sb.in_valid = 1'b1;
        sb.out_ready = 1'b0;
        step();
        sb.in_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (sb.out_valid) begin
                lat = k;
                break;
            end
        end
        check("bp_latency", 128'(lat), 128'd4);
        held = SUBST;
        for (int i = 0; i < 10; i++) begin
            sb.in_valid = i[0];
            sb.inv_mode = ~i[0];
            sb.in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("bp_data_stable", sb.out_data, held);
            check("bp_in_ready", 128'(sb.in_ready), 128'd0);
            check("bp_out_valid", 128'(sb.out_valid), 128'd1);
        end
        sb.in_valid = 1'b0;
        sb.out_ready = 1'b1;
        step();
        check("bp_release_ready", 128'(sb.in_ready), 128'd1);
        check("bp_release_busy", 128'(sb.busy), 128'd0);

        // full table sweep, both modes
        for (int w = 0; w < 16; w++) begin
            for (int i = 0; i < 16; i++) begin
                word[i*8 +: 8] = 8'(16 * w + i);
                exp_f[i*8 +: 8] = ref_fwd[16 * w + i];
                exp_i[i*8 +: 8] = ref_inv[16 * w + i];
            end
            run_word(word, 1'b0, res, lat);
            check($sformatf("table_fwd_w%0d", w), res, exp_f);
            run_word(word, 1'b1, res, lat);
            check($sformatf("table_inv_w%0d", w), res, exp_i);
        end

        // lane-count sweep and forward-only instance
        sw_data = PLAIN;
        sw_ready = 1'b1;
        sw_valid = 1'b1;
        step();
        sw_valid = 1'b0;
        lat_l1 = -1;
        lat_l2 = -1;
        lat_l16 = -1;
        lat_nf = -1;
        res_l1 = '0;
        res_l2 = '0;
        res_l16 = '0;
        res_nf = '0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (if_l1.out_valid && lat_l1 < 0) begin lat_l1 = k; res_l1 = if_l1.out_data; end
            if (if_l2.out_valid && lat_l2 < 0) begin lat_l2 = k; res_l2 = if_l2.out_data; end
            if (if_l16.out_valid && lat_l16 < 0) begin lat_l16 = k; res_l16 = if_l16.out_data; end
            if (if_nf.out_valid && lat_nf < 0) begin lat_nf = k; res_nf = if_nf.out_data; end
        end
        check("l1_latency", 128'(lat_l1), 128'd16);
        check("l1_data", res_l1, SUBST);
        check("l2_latency", 128'(lat_l2), 128'd8);
        check("l2_data", res_l2, SUBST);
        check("l16_latency", 128'(lat_l16), 128'd1);
        check("l16_data", res_l16, SUBST);
        check("nf_latency", 128'(lat_nf), 128'd4);
        check("nf_data", res_nf, SUBST);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
